// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the data memory. Accepts one load or
// store per transaction, screens it for fn3 legality, alignment and range, then
// sequences the memory's one-cycle synchronous read and returns one response.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE_BYTES = 32'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [2:0]  mem_fn3,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK         = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_RANGE      = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL    = 2'b11;

    state_t      state;
    state_t      next_state;
    logic        we_q;
    logic        accept;
    logic [31:0] offset;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [1:0]  err_code;

    assign accept     = (state == IDLE) && req_valid;
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == ACCESS) && we_q;

    // Classify the incoming request: illegal fn3 beats misalignment beats range.
    always_comb begin
        offset       = req_addr - MEM_BASE;
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        err_code     = ERR_OK;
        if (req_we) begin
            illegal = (req_fn3 >= 3'b011);
        end else begin
            illegal = (req_fn3 == 3'b011) || (req_fn3 == 3'b110) || (req_fn3 == 3'b111);
        end
        misaligned   = ((req_fn3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_fn3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        // Unsigned compare: addresses below MEM_BASE wrap to huge offsets.
        out_of_range = (offset >= MEM_SIZE_BYTES);
        if (illegal) begin
            err_code = ERR_ILLEGAL;
        end else if (misaligned) begin
            err_code = ERR_MISALIGNED;
        end else if (out_of_range) begin
            err_code = ERR_RANGE;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing of one transaction.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = (err_code != ERR_OK) ? RESP : ACCESS;
                end
            end
            ACCESS:  next_state = we_q ? RESP : WAIT;
            WAIT:    next_state = RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture, memory-side registers and response data.
    // Memory-side registers load only for requests that reach ACCESS, so a
    // rejected request leaves them holding the previous transaction's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_fn3    <= '0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            if (accept) begin
                resp_rdata <= '0;
                resp_err   <= err_code;
                if (err_code == ERR_OK) begin
                    we_q      <= req_we;
                    mem_addr  <= offset;
                    mem_wdata <= req_wdata;
                    mem_fn3   <= req_fn3;
                end
            end
            if (state == WAIT) begin
                resp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous data memory
// (registered read, combinational extract/sign-extend on mem_fn3).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_fn3;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;

    bit [7:0]  phys_mem [32768];
    bit [7:0]  ref_mem  [32768];
    bit [31:0] rd_word;
    bit [1:0]  rd_off;

    load_store_unit #(
        .MEM_BASE(32'h0000_0000),
        .MEM_SIZE_BYTES(32'd32768)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_fn3(req_fn3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_fn3(mem_fn3),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: byte writes on mem_we, registered word read of mem_addr.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            case (mem_fn3[1:0])
                2'b00: phys_mem[mem_addr[14:0]] <= mem_wdata[7:0];
                2'b01: begin
                    phys_mem[mem_addr[14:0]]         <= mem_wdata[7:0];
                    phys_mem[mem_addr[14:0] + 15'd1] <= mem_wdata[15:8];
                end
                default: begin
                    phys_mem[mem_addr[14:0]]         <= mem_wdata[7:0];
                    phys_mem[mem_addr[14:0] + 15'd1] <= mem_wdata[15:8];
                    phys_mem[mem_addr[14:0] + 15'd2] <= mem_wdata[23:16];
                    phys_mem[mem_addr[14:0] + 15'd3] <= mem_wdata[31:24];
                end
            endcase
        end
        rd_word <= {phys_mem[{mem_addr[14:2], 2'b11}], phys_mem[{mem_addr[14:2], 2'b10}],
                    phys_mem[{mem_addr[14:2], 2'b01}], phys_mem[{mem_addr[14:2], 2'b00}]};
        rd_off  <= mem_addr[1:0];
    end

    // Memory extract/sign-extend, driven by the registered word and mem_fn3.
    always_comb begin
        logic [31:0] sh;
        sh = rd_word >> {rd_off, 3'b000};
        case (mem_fn3)
            3'b000:  mem_rdata = {{24{sh[7]}}, sh[7:0]};
            3'b001:  mem_rdata = {{16{sh[15]}}, sh[15:0]};
            3'b100:  mem_rdata = {24'h0, sh[7:0]};
            3'b101:  mem_rdata = {16'h0, sh[15:0]};
            default: mem_rdata = rd_word;
        endcase
    end

    // Counts cycles with the write enable asserted.
    always @(posedge clk) begin
        if (mem_we === 1'b1) we_cycles++;
    end

    function automatic logic [31:0] ref_load(input logic [2:0] fn3, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a[14:0]];
        b1 = ref_mem[a[14:0] + 15'd1];
        b2 = ref_mem[a[14:0] + 15'd2];
        b3 = ref_mem[a[14:0] + 15'd3];
        case (fn3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] d);
        ref_mem[a[14:0]] = d[7:0];
        if (fn3[1:0] != 2'b00) ref_mem[a[14:0] + 15'd1] = d[15:8];
        if (fn3[1:0] == 2'b10) begin
            ref_mem[a[14:0] + 15'd2] = d[23:16];
            ref_mem[a[14:0] + 15'd3] = d[31:24];
        end
    endtask

    // One full transaction with resp_ready held high. Starts and ends just after
    // a falling edge; lat counts cycles from the acceptance edge to resp_valid.
    task automatic issue(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic [1:0] er, output int lat, output int wes);
        int n;
        int we0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait got %b exp 1", req_ready);
        end
        we0        = we_cycles;
        req_valid  = 1'b1;
        req_we     = we;
        req_fn3    = fn3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        @(negedge clk);
        // Scramble the request bus; the unit must have latched it already.
        req_valid = 1'b0;
        req_we    = ~we;
        req_fn3   = 3'b111;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = ~wdata;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid_timeout got %b exp 1", resp_valid);
        end
        rd = resp_rdata;
        er = resp_err;
        @(negedge clk);
        wes = we_cycles - we0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_fn3    = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL rst_resp_err got %b exp 00", resp_err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (mem_fn3 !== 3'b000) begin errors++; $display("FAIL rst_mem_fn3 got %b exp 000", mem_fn3); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat, wes;
        issue(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, rd, er, lat, wes);
        checks++; if (lat != 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL sw_err got %b exp 00", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 0", rd); end
        checks++; if (wes != 1) begin errors++; $display("FAIL sw_we_cycles got %0d exp 1", wes); end
        issue(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wes);
        checks++; if (lat != 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
        checks++; if (er !== 2'b00) begin errors++; $display("FAIL lw_err got %b exp 00", er); end
        checks++; if (wes != 0) begin errors++; $display("FAIL lw_we_cycles got %0d exp 0", wes); end
    endtask

    task automatic test_extension;
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat, wes;
        issue(1'b1, 3'b000, 32'h41, 32'h0000_AB80, rd, er, lat, wes);
        checks++; if (er !== 2'b00 || wes != 1) begin errors++; $display("FAIL sb_err_we got %b/%0d exp 00/1", er, wes); end
        issue(1'b0, 3'b000, 32'h41, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rd); end
        issue(1'b0, 3'b100, 32'h41, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", rd); end
        issue(1'b1, 3'b001, 32'h42, 32'h1234_8001, rd, er, lat, wes);
        checks++; if (er !== 2'b00 || wes != 1) begin errors++; $display("FAIL sh_err_we got %b/%0d exp 00/1", er, wes); end
        issue(1'b0, 3'b001, 32'h42, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata got %h exp ffff8001", rd); end
        issue(1'b0, 3'b101, 32'h42, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", rd); end
        issue(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'h8001_80EF) begin errors++; $display("FAIL lw_merged got %h exp 800180ef", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat, wes;
        logic        we_v   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  fn3_v  [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b010};
        logic [31:0] addr_v [7] = '{32'h42, 32'h43, 32'h8000, 32'h45, 32'h40, 32'hFFFF_FFFF, 32'h8002};
        logic [1:0]  exp_v  [7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01};
        for (int i = 0; i < 7; i++) begin
            issue(we_v[i], fn3_v[i], addr_v[i], 32'h5555_1234, rd, er, lat, wes);
            checks++; if (er !== exp_v[i]) begin errors++; $display("FAIL err_code[%0d] got %b exp %b", i, er, exp_v[i]); end
            checks++; if (lat != 1) begin errors++; $display("FAIL err_latency[%0d] got %0d exp 1", i, lat); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d] got %h exp 0", i, rd); end
            checks++; if (wes != 0) begin errors++; $display("FAIL err_we_cycles[%0d] got %0d exp 0", i, wes); end
        end
        issue(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'h8001_80EF) begin errors++; $display("FAIL err_no_write got %h exp 800180ef", rd); end
    endtask

    task automatic test_backpressure;
        int n;
        int we0;
        we0        = we_cycles;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_fn3    = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", n); end
        // A store offered during the stalled response must not be taken.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_fn3   = 3'b010;
        req_addr  = 32'h40;
        req_wdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, resp_valid); end
            checks++; if (resp_rdata !== 32'h8001_80EF) begin errors++; $display("FAIL bp_rdata[%0d] got %h exp 800180ef", i, resp_rdata); end
            checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL bp_err[%0d] got %b exp 00", i, resp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %b exp 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_ready got %b exp 1", req_ready); end
        @(negedge clk);
        checks++; if (we_cycles != we0) begin errors++; $display("FAIL bp_no_accept got %0d exp %0d", we_cycles, we0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat, wes;
        // Reset while the load waits on the memory read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_fn3   = 3'b010;
        req_addr  = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rwait_valid got %b exp 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rwait_ready_in_rst got %b exp 0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rwait_ready got %b exp 1", req_ready); end
        issue(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'h8001_80EF || lat != 3) begin errors++; $display("FAIL rwait_reload got %h/%0d exp 800180ef/3", rd, lat); end
        // Reset during the store's ACCESS cycle: the write still lands.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_fn3   = 3'b010;
        req_addr  = 32'h48;
        req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL racc_mem_we got %b exp 0", mem_we); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL racc_valid got %b exp 0", resp_valid); end
        rst = 1'b0;
        #1;
        issue(1'b0, 3'b010, 32'h48, 32'h0, rd, er, lat, wes);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL racc_write got %h exp cafef00d", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, a, wd, exp_rd;
        logic [1:0]  er;
        logic [2:0]  fn3;
        logic        we;
        int          lat, wes, sz;
        for (int i = 0; i < 40; i++) begin
            we  = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            sz  = $urandom_range(0, 2);
            a   = 32'h100 + ($urandom_range(0, 63) & ~((1 << sz) - 1));
            fn3 = 3'(sz);
            if (!we && sz != 2 && $urandom_range(0, 1) == 1) fn3[2] = 1'b1;
            wd  = $urandom;
            if (we) begin
                ref_store(fn3, a, wd);
                exp_rd = 32'h0;
            end else begin
                exp_rd = ref_load(fn3, a);
            end
            issue(we, fn3, a, wd, rd, er, lat, wes);
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rd, exp_rd); end
            checks++; if (er !== 2'b00) begin errors++; $display("FAIL b2b_err[%0d] got %b exp 00", i, er); end
            checks++; if (lat != (we ? 2 : 3)) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, lat, we ? 2 : 3); end
            checks++; if (wes != int'(we)) begin errors++; $display("FAIL b2b_we_cycles[%0d] got %0d exp %0d", i, wes, we); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
